// File: rtl/phys_reg_file_bypass.sv
// Physical register file: NUM_RD combinational reads, NUM_WR writebacks with optional
// write-to-read bypass, per-register ready scoreboard and a post-reset init sweep.
`timescale 1ns/100ps
module phys_reg_file_bypass #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_ALLOC = 2,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic [$clog2(NUM_PREGS)-1:0] rd_reg      [NUM_RD],
  output logic [DATA_W-1:0]            rd_val      [NUM_RD],
  output logic                         rd_rdy      [NUM_RD],
  input  logic                         wr_valid    [NUM_WR],
  input  logic [$clog2(NUM_PREGS)-1:0] wr_reg      [NUM_WR],
  input  logic [DATA_W-1:0]            wr_val      [NUM_WR],
  input  logic                         alloc_valid [NUM_ALLOC],
  input  logic [$clog2(NUM_PREGS)-1:0] alloc_reg   [NUM_ALLOC],
  output logic                         wr_conflict
);

  localparam int unsigned IDX_W = $clog2(NUM_PREGS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PREGS - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       init_cnt_q;
  logic [NUM_PREGS-1:0]   rdy_q;
  logic [NUM_PREGS-1:0]   rdy_d;
  logic [DATA_W-1:0]      mem_q [NUM_PREGS];
  logic                   conflict;

  // Ready next-state: writes set, allocs clear afterwards so alloc wins a same-cycle race.
  always_comb begin
    rdy_d = rdy_q;
    if (state_q == StInit) begin
      rdy_d[init_cnt_q] = 1'b1;
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_valid[w] && wr_reg[w] != '0) rdy_d[wr_reg[w]] = 1'b1;
      end
      for (int a = 0; a < int'(NUM_ALLOC); a++) begin
        if (alloc_valid[a] && alloc_reg[a] != '0) rdy_d[alloc_reg[a]] = 1'b0;
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      for (int j = i + 1; j < int'(NUM_WR); j++) begin
        if (wr_valid[i] && wr_valid[j] && wr_reg[i] == wr_reg[j] && wr_reg[i] != '0) begin
          conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done   <= 1'b0;
      wr_conflict <= 1'b0;
      rdy_q       <= '0;
    end else begin
      rdy_q       <= rdy_d;
      wr_conflict <= (state_q == StRun) && conflict;
      case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastIdx) begin
            state_q   <= StRun;
            init_done <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Data array has no reset; the init sweep zeroes it. Later write ports override earlier.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[init_cnt_q] <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_valid[w] && wr_reg[w] != '0) mem_q[wr_reg[w]] <= wr_val[w];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_RD); r++) begin
      rd_val[r] = '0;
      rd_rdy[r] = 1'b0;
      if (state_q == StRun) begin
        if (rd_reg[r] == '0) begin
          rd_rdy[r] = 1'b1;
        end else begin
          rd_val[r] = mem_q[rd_reg[r]];
          rd_rdy[r] = rdy_q[rd_reg[r]];
          if (BYPASS != 0) begin
            for (int w = 0; w < int'(NUM_WR); w++) begin
              if (wr_valid[w] && wr_reg[w] == rd_reg[r]) begin
                rd_val[r] = wr_val[w];
                rd_rdy[r] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_file_bypass.sv
// Bench for phys_reg_file_bypass: bypassing and non-bypassing instances share stimulus and
// are checked against a cycle-level array model plus a directed vector table.
`timescale 1ns/100ps
module tb_phys_reg_file_bypass;

  localparam int NP = 64;
  localparam int NR = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  rd_reg      [NR];
  logic        wr_valid    [2];
  logic [5:0]  wr_reg      [2];
  logic [31:0] wr_val      [2];
  logic        alloc_valid [2];
  logic [5:0]  alloc_reg   [2];

  logic        init_done_bp, init_done_nb, conf_bp, conf_nb;
  logic [31:0] rd_val_bp [NR];
  logic [31:0] rd_val_nb [NR];
  logic        rd_rdy_bp [NR];
  logic        rd_rdy_nb [NR];

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] m_mem [NP];
  bit          m_rdy [NP];
  bit          m_run;
  int          m_cnt;
  bit          m_conf;

  phys_reg_file_bypass #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done_bp),
    .rd_reg(rd_reg), .rd_val(rd_val_bp), .rd_rdy(rd_rdy_bp),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_val(wr_val),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .wr_conflict(conf_bp)
  );

  phys_reg_file_bypass #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .init_done(init_done_nb),
    .rd_reg(rd_reg), .rd_val(rd_val_nb), .rd_rdy(rd_rdy_nb),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_val(wr_val),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .wr_conflict(conf_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic        wv0; logic [5:0] wr0; logic [31:0] wd0;
    logic        wv1; logic [5:0] wr1; logic [31:0] wd1;
    logic        av0; logic [5:0] ar0;
    logic [5:0]  rr;
    logic [31:0] ev;    logic er;
    logic [31:0] ev_nb; logic er_nb;
    logic        ec;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic wv0, logic [5:0] wr0, logic [31:0] wd0,
                              logic wv1, logic [5:0] wr1, logic [31:0] wd1,
                              logic av0, logic [5:0] ar0, logic [5:0] rr,
                              logic [31:0] ev, logic er, logic [31:0] ev_nb, logic er_nb,
                              logic ec);
    vec_t v;
    v.wv0 = wv0; v.wr0 = wr0; v.wd0 = wd0; v.wv1 = wv1; v.wr1 = wr1; v.wd1 = wd1;
    v.av0 = av0; v.ar0 = ar0; v.rr = rr; v.ev = ev; v.er = er; v.ev_nb = ev_nb;
    v.er_nb = er_nb; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    m_conf = 1'b0;
    for (int i = 0; i < NP; i++) m_rdy[i] = 1'b0;
  endfunction

  // Expected read for one port: INIT masks everything, preg 0 is constant, bypass forwards
  // the last valid same-register write.
  function automatic void exp_read(input int p, input bit bp, output logic [31:0] v,
                                   output logic r);
    int a = int'(rd_reg[p]);
    v = 32'h0;
    r = 1'b0;
    if (!m_run) return;
    if (a == 0) begin
      r = 1'b1;
      return;
    end
    v = m_mem[a];
    r = m_rdy[a];
    if (bp) begin
      for (int w = 0; w < 2; w++) begin
        if (wr_valid[w] && int'(wr_reg[w]) == a) begin
          v = wr_val[w];
          r = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_edge();
    bit c = 1'b0;
    if (!m_run) begin
      m_mem[m_cnt] = 32'h0;
      m_rdy[m_cnt] = 1'b1;
      if (m_cnt == NP - 1) m_run = 1'b1;
      m_cnt = (m_cnt + 1) % NP;
      m_conf = 1'b0;
      return;
    end
    c = wr_valid[0] && wr_valid[1] && wr_reg[0] == wr_reg[1] && wr_reg[0] != 6'd0;
    for (int w = 0; w < 2; w++) begin
      if (wr_valid[w] && wr_reg[w] != 6'd0) begin
        m_mem[wr_reg[w]] = wr_val[w];
        m_rdy[wr_reg[w]] = 1'b1;
      end
    end
    for (int a = 0; a < 2; a++) begin
      if (alloc_valid[a] && alloc_reg[a] != 6'd0) m_rdy[alloc_reg[a]] = 1'b0;
    end
    m_conf = c;
  endfunction

  task automatic check_all();
    logic [31:0] v;
    logic r;
    check("init_done bp", init_done_bp, m_run);
    check("init_done nb", init_done_nb, m_run);
    check("wr_conflict bp", conf_bp, m_conf);
    check("wr_conflict nb", conf_nb, m_conf);
    for (int p = 0; p < NR; p++) begin
      exp_read(p, 1'b1, v, r);
      check($sformatf("rd_val[%0d] bp reg%0d", p, rd_reg[p]), rd_val_bp[p], v);
      check($sformatf("rd_rdy[%0d] bp reg%0d", p, rd_reg[p]), rd_rdy_bp[p], r);
      exp_read(p, 1'b0, v, r);
      check($sformatf("rd_val[%0d] nb reg%0d", p, rd_reg[p]), rd_val_nb[p], v);
      check($sformatf("rd_rdy[%0d] nb reg%0d", p, rd_reg[p]), rd_rdy_nb[p], r);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    for (int w = 0; w < 2; w++) begin
      wr_valid[w] = 1'b0; wr_reg[w] = 6'd0; wr_val[w] = 32'h0;
      alloc_valid[w] = 1'b0; alloc_reg[w] = 6'd0;
    end
    for (int p = 0; p < NR; p++) rd_reg[p] = 6'd0;
  endtask

  task automatic set_random(input int max_reg);
    for (int w = 0; w < 2; w++) begin
      wr_valid[w] = 1'($urandom_range(0, 1));
      wr_reg[w] = 6'($urandom_range(0, max_reg));
      wr_val[w] = $urandom;
      alloc_valid[w] = ($urandom_range(0, 3) == 0);
      alloc_reg[w] = 6'($urandom_range(0, max_reg));
    end
    for (int p = 0; p < NR; p++) rd_reg[p] = 6'($urandom_range(0, max_reg));
  endtask

  // Sweep of NP edges with junk inputs that must be ignored; init_done rises after edge NP.
  task automatic run_init();
    for (int e = 0; e < NP; e++) begin
      set_random(NP - 1);
      sample();
      check($sformatf("init_done before edge %0d", e + 1), init_done_bp, 1'b0);
      check("rd_rdy[0] in init", rd_rdy_bp[0], 1'b0);
      tick();
    end
    set_idle();
    sample();
    check("init_done after sweep bp", init_done_bp, 1'b1);
    check("init_done after sweep nb", init_done_nb, 1'b1);
    tick();
  endtask

  initial begin
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 32'h0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 32'h0, 1, 32'h0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0, 0, 32'h0, 0, 0);
    tbl[4]  = mk(1, 9, 32'h1234, 0, 0, 0, 1, 9, 9, 32'h1234, 1, 32'h0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h1234, 0, 32'h1234, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 9, 32'h1234, 0, 0, 9, 32'h1234, 1, 32'h1234, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h1234, 1, 32'h1234, 1, 0);
    tbl[8]  = mk(1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 7, 32'h5555, 1, 32'h0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h5555, 1, 32'h5555, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h5555, 1, 32'h5555, 1, 0);
    tbl[11] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 1, 32'h0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0);
    tbl[13] = mk(1, 12, 32'h77, 1, 12, 32'h77, 0, 0, 12, 32'h77, 1, 32'h0, 1, 0);

    set_idle();
    model_reset();
    rst = 1'b0;
    #2;
    check_all();
    check("reset init_done", init_done_bp, 1'b0);
    check("reset wr_conflict", conf_bp, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_init();

    // Every register zeroed and ready after the sweep
    for (int b = 0; b < NP; b += NR) begin
      for (int p = 0; p < NR; p++) rd_reg[p] = 6'(b + p);
      sample();
      for (int p = 0; p < NR; p++) begin
        check($sformatf("post-init val reg%0d", b + p), rd_val_nb[p], 32'h0);
        check($sformatf("post-init rdy reg%0d", b + p), rd_rdy_nb[p], 1'b1);
      end
      tick();
    end

    for (int i = 0; i < 14; i++) begin
      set_idle();
      wr_valid[0] = tbl[i].wv0; wr_reg[0] = tbl[i].wr0; wr_val[0] = tbl[i].wd0;
      wr_valid[1] = tbl[i].wv1; wr_reg[1] = tbl[i].wr1; wr_val[1] = tbl[i].wd1;
      alloc_valid[0] = tbl[i].av0; alloc_reg[0] = tbl[i].ar0;
      for (int p = 0; p < NR; p++) rd_reg[p] = tbl[i].rr;
      sample();
      for (int p = 0; p < NR; p++) begin
        check($sformatf("vec%0d rd_val[%0d] bp", i, p), rd_val_bp[p], tbl[i].ev);
        check($sformatf("vec%0d rd_rdy[%0d] bp", i, p), rd_rdy_bp[p], tbl[i].er);
        check($sformatf("vec%0d rd_val[%0d] nb", i, p), rd_val_nb[p], tbl[i].ev_nb);
        check($sformatf("vec%0d rd_rdy[%0d] nb", i, p), rd_rdy_nb[p], tbl[i].er_nb);
      end
      check($sformatf("vec%0d wr_conflict", i), conf_bp, tbl[i].ec);
      tick();
    end

    // Mid-operation reset right after the reg12 collision edge
    set_idle();
    for (int p = 0; p < NR; p++) rd_reg[p] = 6'd12;
    check("pre-reset wr_conflict", conf_bp, 1'b1);
    #1;
    rst = 1'b0;
    model_reset();
    #0.5;
    check_all();
    check("mid-reset init_done", init_done_bp, 1'b0);
    check("mid-reset wr_conflict", conf_bp, 1'b0);
    for (int p = 0; p < NR; p++) check($sformatf("mid-reset rd_rdy[%0d]", p), rd_rdy_bp[p], 1'b0);
    #0.5;
    rst = 1'b1;

    run_init();
    for (int p = 0; p < NR; p++) rd_reg[p] = 6'd12;
    sample();
    check("reg12 after re-init val", rd_val_bp[0], 32'h0);
    check("reg12 after re-init rdy", rd_rdy_bp[0], 1'b1);
    tick();

    for (int n = 0; n < 400; n++) begin
      set_random((n % 4 == 0) ? NP - 1 : 15);
      sample();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phys_reg_file_bypass.md
# phys_reg_file_bypass

Parametrised physical register file for the out-of-order backend, the successor to the fixed 32-bit, per-FU register file. It provides NUM_RD combinational read ports, NUM_WR writeback ports with optional write-to-read bypass, and a per-register ready scoreboard that rename clears on allocation and writeback sets. After reset it runs a sequential init sweep, so no asynchronous reset is needed on the data array. It sits between rename/issue (alloc and read) and the execute writeback bus.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_PREGS, 64, number of physical registers (≥4, power of two); IDX_W = $clog2(NUM_PREGS)
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports
- NUM_ALLOC, 2, allocation (ready-clear) ports
- BYPASS, 1, 1 = same-cycle write data forwarded to readers; 0 = old data read

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- init_done  out  1  high once the init sweep completes
- rd_reg[NUM_RD]  in  IDX_W  read address per port
- rd_val[NUM_RD]  out  DATA_W  read data, combinational
- rd_rdy[NUM_RD]  out  1  ready bit of addressed register, combinational
- wr_valid[NUM_WR]  in  1  writeback valid
- wr_reg[NUM_WR]  in  IDX_W  writeback destination
- wr_val[NUM_WR]  in  DATA_W  writeback data
- alloc_valid[NUM_ALLOC]  in  1  rename allocates a preg
- alloc_reg[NUM_ALLOC]  in  IDX_W  allocated preg; its ready bit is cleared
- wr_conflict  out  1  registered pulse: ≥2 valid write ports targeted the same nonzero reg last cycle

## Operation
- Storage: data array (no reset) and ready vector rdy[NUM_PREGS] (async reset).
- Control FSM has two states, INIT and RUN. Counter init_cnt is IDX_W bits.
- On rst low (async), the block enters INIT:
  - init_cnt=0, init_done=0, wr_conflict=0, rdy=all 0.
- INIT, each posedge:
  - array[init_cnt]←0 and rdy[init_cnt]←1, then init_cnt++.
  - When init_cnt==NUM_PREGS-1, the state goes to RUN and init_done←1.
- INIT rules:
  - wr_valid and alloc_valid are ignored.
  - rd_val=0 and rd_rdy=0 on all ports.
- RUN: init_done stays 1 until the next reset.
- Preg 0 is hardwired:
  - Reads return 0 with rd_rdy=1.
  - Writes and allocs to 0 are dropped.
  - Preg 0 is never counted in wr_conflict.
- Write (RUN): for each valid write port with wr_reg≠0, array[wr_reg]←wr_val and rdy[wr_reg]←1.
  - Same-reg collision: the highest-index port wins, and wr_conflict←1 next cycle.
- Alloc (RUN): rdy[alloc_reg]←0.
  - Alloc and write to the same reg in the same cycle: alloc wins, so rdy=0 while data is still written.
  - Duplicate allocs of the same reg are harmless.
- Read (RUN):
  - Default: rd_val=array[rd_reg], rd_rdy=rdy[rd_reg].
  - With BYPASS=1, a same-cycle valid write to rd_reg (≠0) returns the winning wr_val with rd_rdy=1. An alloc on the same reg in that cycle does not affect the current-cycle rd_rdy.
  - With BYPASS=0, the read returns the pre-edge array value and rdy.
- Reset mid-operation (rst low at any time) restarts INIT from init_cnt=0; all ready bits read 0 until re-swept.

## Timing
- Reset values: init_done=0, wr_conflict=0, rd_val=0, rd_rdy=0.
- init_done rises after exactly NUM_PREGS posedges following rst release. The first posedge after rst deassertion writes preg 0.
- Read latency is 0 cycles (combinational from rd_reg, plus wr_* when BYPASS=1).
- Write latency: data is visible on a non-bypassed read the cycle after wr_valid.
- Alloc latency: the rdy clear is visible the cycle after alloc_valid.
- wr_conflict is a one-cycle pulse, asserted the cycle after the colliding writes. It is 0 in INIT.
- No handshakes or backpressure; all inputs are sampled every RUN cycle.

## Test plan
- Reset/init, NUM_PREGS=64:
  - Release rst and count edges: init_done=0 for 63 edges and 1 after edge 64.
  - Any read during INIT returns 0 with rdy=0.
  - After init, all regs read 0 with rdy=1.
- Write/read, BYPASS=1:
  - wr port0 reg5=0xDEADBEEF with rd port0 on reg5 in the same cycle returns 0xDEADBEEF, rdy=1.
  - The next cycle, with no write, still returns 0xDEADBEEF.
  - With BYPASS=0, the same-cycle read returns 0 and the next cycle returns 0xDEADBEEF.
- Alloc/write race:
  - Alloc reg9 alone: rd_rdy(9)=0 the next cycle.
  - Alloc reg9 with wr reg9=0x1234 in the same cycle: the next cycle reads 0x1234 with rdy=0.
  - A later lone write to reg9 makes rdy=1.
- Write collision:
  - wr0 reg7=0xAAAA and wr1 reg7=0x5555 in one cycle: reg7 reads 0x5555 next cycle and wr_conflict=1 for exactly one cycle.
  - Both ports writing reg0 gives wr_conflict=0.
- Preg 0:
  - Write 0xFFFF_FFFF to reg0 and alloc reg0: reg0 reads 0 with rdy=1 on all read ports.
- Mid-operation reset:
  - Write reg12=0x77, then pulse rst low for 1 ns between edges.
  - init_done and wr_conflict drop immediately, and rd_rdy=0 everywhere.
  - After 64 edges, reg12 reads 0 with rdy=1.
